ir_queue: RTL and testbench
===========================

# ir_queue

Parametrised instruction register/queue between fetch and decode in the LC-3b pipeline. Buffers up to DEPTH fetched instruction words with their PCs and presents the head entry with pre-split decode fields (opcode, dest, src1, src2, ir5, ir11). Valid/ready handshakes on both sides and a single-cycle flush for branch redirect. Supersedes the single-entry load-enabled IR.

## Interface
Parameters:
- DEPTH, 4, entry count; power of 2, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries
- in_valid  in  1  fetch offers an entry
- in_ready  out  1  queue accepts an entry
- in_instr  in  lc3b_word  fetched instruction
- in_pc  in  lc3b_word  PC of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head
- out_instr  out  lc3b_word  head instruction
- out_pc  out  lc3b_word  head PC
- opcode  out  lc3b_opcode  out_instr[15:12]
- dest  out  lc3b_reg  out_instr[11:9]
- src1  out  lc3b_reg  out_instr[8:6]
- src2  out  lc3b_reg  out_instr[2:0]
- ir5  out  1  out_instr[5]
- ir11  out  1  out_instr[11]
- count  out  $clog2(DEPTH+1)  occupied entries
- almost_full  out  1  count ≥ AF_LEVEL

## Operation
- Circular buffer: wr_ptr, rd_ptr each $clog2(DEPTH) bits, natural wrap DEPTH-1 → 0; count tracked separately.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); no dependence on out_ready (full queue never accepts, even with simultaneous pop).
- out_valid = (count != 0).
- push only: write entry at wr_ptr, wr_ptr+1, count+1. pop only: rd_ptr+1, count-1. push and pop together: both pointers advance, count unchanged.
- flush (or rst): count, wr_ptr, rd_ptr ← 0; overrides push and pop in the same cycle; pushed word dropped, popped entry still considered consumed by decode.
- Head outputs: when out_valid=1, out_instr/out_pc = entry at rd_ptr; when out_valid=0, out_instr=16'h0000 and out_pc=16'h0000, so decode fields read opcode 0, regs 0, ir5=ir11=0.
- Storage array is not reset; only pointers/count.
- in_valid with in_ready=0: no state change; fetch must hold.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, almost_full=0, out_instr=out_pc=0, all decode fields 0.
- Push-to-head latency: 1 cycle (entry pushed at edge N visible on out_* after edge N; no combinational bypass from in_* to out_*).
- Pop-to-next-head: next entry visible after the popping edge.
- Full-to-ready: after a pop from full, in_ready rises after that edge.
- count, almost_full, in_ready, out_valid are functions of registered state only.
- Flush/rst asserted at edge N: after edge N queue empty, in_ready=1; push on edge N+1 valid.

## Structure
- lc3b_types package gains lc3b_ibuf_entry struct {lc3b_word instr; lc3b_word pc}; lc3b_opcode/lc3b_reg/lc3b_word reused.
- Sub-module ir_fields: combinational split of a lc3b_word into opcode, dest, src1, src2, ir5, ir11; instantiated on the head word.
- Elaboration check: DEPTH power of 2, AF_LEVEL in range.

## Test plan (DEPTH=4, AF_LEVEL=3)
- Reset, hold idle 3 cycles -> out_valid=0, in_ready=1, count=0, opcode=0, out_instr=0.
- Push 16'h1283 pc 16'h3000, out_ready=0 -> next cycle out_valid=1, opcode=4'h1, dest=1, src1=2, src2=3, ir5=0, ir11=0, out_pc=16'h3000.
- Push 5 words 16'hA000..16'hA004, out_ready=0 -> first 4 accepted, almost_full=1 at count=3, in_ready=0 at count=4, fifth held; pop all -> order A000..A003.
- Continuous push+pop for 10 cycles at count=2 -> count stays 2, pointers wrap, outputs in push order, no loss.
- Count=3, assert flush with in_valid=1 and out_ready=1 same cycle -> next cycle count=0, out_valid=0, pushed word absent.
- Mid-stream rst with count=4 -> next cycle all reset values; new push 16'h2E3F appears as head, opcode=4'h2, ir5=1, ir11=1.

Source files
------------

// File: rtl/ir_queue_pkg.sv
// Shared LC-3b word/field types and the instruction-buffer entry layout
// used by the fetch/decode instruction queue.
package ir_queue_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;
    typedef logic [2:0]  lc3b_reg;

    typedef struct packed {
        lc3b_word instr;
        lc3b_word pc;
    } lc3b_ibuf_entry;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ir_queue_if.sv
// Fetch-side and decode-side signal bundle of the instruction queue.
// The queue itself uses the slave view; the fetch/decode environment uses master.
interface ir_queue_if #(parameter int DEPTH = 4);
    import ir_queue_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    lc3b_word      in_instr;
    lc3b_word      in_pc;

    logic          out_valid;
    logic          out_ready;
    lc3b_word      out_instr;
    lc3b_word      out_pc;
    lc3b_opcode    opcode;
    lc3b_reg       dest;
    lc3b_reg       src1;
    lc3b_reg       src2;
    logic          ir5;
    logic          ir11;

    logic [CW-1:0] count;
    logic          almost_full;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  opcode, dest, src1, src2, ir5, ir11, count, almost_full
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output opcode, dest, src1, src2, ir5, ir11, count, almost_full
    );

endinterface

// File: rtl/ir_queue_fields.sv
// Combinational split of an LC-3b instruction word into the fields decode
// looks at first.
module ir_fields
    import ir_queue_pkg::*;
(
    input  lc3b_word   word,
    output lc3b_opcode opcode,
    output lc3b_reg    dest,
    output lc3b_reg    src1,
    output lc3b_reg    src2,
    output logic       ir5,
    output logic       ir11
);

    assign opcode = word[15:12];
    assign dest   = word[11:9];
    assign src1   = word[8:6];
    assign src2   = word[2:0];
    assign ir5    = word[5];
    assign ir11   = word[11];

    // bits 4:3 are not a field of their own in any format decode cares about
    logic unused_bits;
    assign unused_bits = ^word[4:3];

endmodule

// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: circular buffer of DEPTH
// {instr, pc} entries, head presented with pre-split decode fields.
module ir_queue
    import ir_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    ir_queue_if.slave  q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
            $error("ir_queue: DEPTH must be a power of 2 and at least 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("ir_queue: AF_LEVEL must lie in 1..DEPTH");
        end
    endgenerate

    lc3b_ibuf_entry mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic           push;
    logic           pop;
    lc3b_ibuf_entry head;

    // in_ready deliberately ignores out_ready: a full queue never accepts
    assign q.in_ready    = (count_q != CW'(DEPTH));
    assign q.out_valid   = (count_q != '0);
    assign q.count       = count_q;
    assign q.almost_full = (count_q >= CW'(AF_LEVEL));

    assign push = q.in_valid & q.in_ready;
    assign pop  = q.out_valid & q.out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // storage is not reset; a write under flush lands in a slot nobody counts
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: q.in_instr, pc: q.in_pc};
        end
    end

    assign head        = mem[rd_ptr];
    assign q.out_instr = q.out_valid ? head.instr : '0;
    assign q.out_pc    = q.out_valid ? head.pc    : '0;

    ir_fields u_fields (
        .word   (q.out_instr),
        .opcode (q.opcode),
        .dest   (q.dest),
        .src1   (q.src1),
        .src2   (q.src2),
        .ir5    (q.ir5),
        .ir11   (q.ir11)
    );

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue (DEPTH=4, AF_LEVEL=3): directed scenarios plus random
// traffic, checked against a queue-based model of the buffer contents.
module tb_ir_queue;
    import ir_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic clk;
    logic rst;
    logic flush;

    ir_queue_if #(.DEPTH(DEPTH)) qi ();

    ir_queue #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q     (qi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    bit last_push = 1'b0;
    lc3b_ibuf_entry exp_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // model: a FIFO of what fetch handed over and decode has not yet taken
    always @(posedge clk) begin
        bit push_m;
        bit pop_m;
        push_m = qi.in_valid && (exp_q.size() != DEPTH);
        pop_m  = (exp_q.size() != 0) && qi.out_ready;
        last_push = push_m && !rst && !flush;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) exp_q.push_back('{instr: qi.in_instr, pc: qi.in_pc});
        end
    end

    always @(negedge clk) begin
        lc3b_word h;
        if (mon_en) begin
            check("count", 32'(qi.count), 32'(exp_q.size()));
            check("in_ready", 32'(qi.in_ready), 32'(exp_q.size() != DEPTH));
            check("out_valid", 32'(qi.out_valid), 32'(exp_q.size() != 0));
            check("almost_full", 32'(qi.almost_full), 32'(exp_q.size() >= AF));
            h = (exp_q.size() != 0) ? exp_q[0].instr : 16'h0000;
            check("out_instr", 32'(qi.out_instr), 32'(h));
            check("out_pc", 32'(qi.out_pc), (exp_q.size() != 0) ? 32'(exp_q[0].pc) : 32'h0);
            check("opcode", 32'(qi.opcode), 32'(h[15:12]));
            check("dest", 32'(qi.dest), 32'(h[11:9]));
            check("src1", 32'(qi.src1), 32'(h[8:6]));
            check("src2", 32'(qi.src2), 32'(h[2:0]));
            check("ir5", 32'(qi.ir5), 32'(h[5]));
            check("ir11", 32'(qi.ir11), 32'(h[11]));
        end
    end

    task automatic drive(input logic v, input lc3b_word i, input lc3b_word p,
                         input logic ordy, input logic fl, input logic r);
        qi.in_valid  = v;
        qi.in_instr  = i;
        qi.in_pc     = p;
        qi.out_ready = ordy;
        flush        = fl;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input lc3b_word base, input int n);
        int k = 0;
        for (int g = 0; g < 20 && k < n; g++) begin
            drive(1'b1, base + 16'(k), 16'h5000 + 16'(k), 1'b0, 1'b0, 1'b0);
            if (last_push) k++;
        end
        check("fill_done", 32'(k), 32'(n));
    endtask

    task automatic drain();
        for (int g = 0; g < 10 && exp_q.size() != 0; g++)
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic     cur_v;
        lc3b_word cur_w;
        int       k;

        qi.in_valid = 1'b0; qi.in_instr = '0; qi.in_pc = '0; qi.out_ready = 1'b0;
        flush = 1'b0; rst = 1'b1;

        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_out_valid", 32'(qi.out_valid), 32'd0);
        check("rst_in_ready", 32'(qi.in_ready), 32'd1);
        check("rst_count", 32'(qi.count), 32'd0);
        check("rst_opcode", 32'(qi.opcode), 32'd0);
        check("rst_out_instr", 32'(qi.out_instr), 32'd0);

        drive(1'b1, 16'h1283, 16'h3000, 1'b0, 1'b0, 1'b0);
        qi.in_valid = 1'b0;
        @(negedge clk);
        check("p1_out_valid", 32'(qi.out_valid), 32'd1);
        check("p1_opcode", 32'(qi.opcode), 32'h1);
        check("p1_dest", 32'(qi.dest), 32'd1);
        check("p1_src1", 32'(qi.src1), 32'd2);
        check("p1_src2", 32'(qi.src2), 32'd3);
        check("p1_ir5", 32'(qi.ir5), 32'd0);
        check("p1_ir11", 32'(qi.ir11), 32'd0);
        check("p1_out_pc", 32'(qi.out_pc), 32'h3000);
        drain();

        k = 0;
        for (int g = 0; g < 20 && k < 4; g++) begin
            drive(1'b1, 16'hA000 + 16'(k), 16'h3100 + 16'(k), 1'b0, 1'b0, 1'b0);
            if (last_push) begin
                k++;
                @(negedge clk);
                check("fill_af", 32'(qi.almost_full), 32'(k >= 3));
            end
        end
        drive(1'b1, 16'hA004, 16'h3104, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("full_count", 32'(qi.count), 32'd4);
        check("full_in_ready", 32'(qi.in_ready), 32'd0);
        check("full_af", 32'(qi.almost_full), 32'd1);
        qi.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("order_instr", 32'(qi.out_instr), 32'hA000 + 32'(j));
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("order_empty", 32'(qi.out_valid), 32'd0);

        fill(16'hB000, 2);
        for (int i = 0; i < 10; i++)
            drive(1'b1, 16'hB100 + 16'(i), 16'h3200 + 16'(i), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("stream_count", 32'(qi.count), 32'd2);
        check("stream_head", 32'(qi.out_instr), 32'hB108);
        drain();

        fill(16'hC000, 3);
        drive(1'b1, 16'hC0FF, 16'h3300, 1'b1, 1'b1, 1'b0);
        qi.in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_count", 32'(qi.count), 32'd0);
        check("flush_out_valid", 32'(qi.out_valid), 32'd0);
        check("flush_in_ready", 32'(qi.in_ready), 32'd1);

        fill(16'hD000, 4);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_count", 32'(qi.count), 32'd0);
        check("mrst_in_ready", 32'(qi.in_ready), 32'd1);
        check("mrst_almost_full", 32'(qi.almost_full), 32'd0);
        check("mrst_out_instr", 32'(qi.out_instr), 32'd0);
        drive(1'b1, 16'h2E3F, 16'h4000, 1'b0, 1'b0, 1'b0);
        qi.in_valid = 1'b0;
        @(negedge clk);
        check("mrst_head", 32'(qi.out_instr), 32'h2E3F);
        check("mrst_opcode", 32'(qi.opcode), 32'h2);
        check("mrst_ir5", 32'(qi.ir5), 32'd1);
        check("mrst_ir11", 32'(qi.ir11), 32'd1);
        check("mrst_dest", 32'(qi.dest), 32'd7);
        drain();

        cur_v = 1'b0;
        cur_w = '0;
        for (int i = 0; i < 400; i++) begin
            // fetch holds an offered word until the queue takes it
            if (!(cur_v && !last_push)) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_w = 16'($urandom);
            end
            drive(cur_v, cur_w, 16'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        drain();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
